// File: rtl/zz_pkg.sv
// Shared types, sizing and fixed-point helpers for the delta stream unit.
// Narrowing saturates when ZZ_DELTA_SATURATE_EN is defined, otherwise it wraps.
package zz_pkg;

   localparam int DATA_SIZE = 16;
   localparam int SIZE      = 3;
   localparam int FRAC_BITS = 8;
   localparam int LAYER_W   = 4;
   localparam int IDX_W     = $clog2(SIZE);
   localparam int ACC_W     = 2*DATA_SIZE + $clog2(SIZE);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } zz_state_t;

   typedef struct packed {
      logic                        ovf;
      logic signed [DATA_SIZE-1:0] val;
   } fx_res_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      $signed({{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      $signed({{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}});

   // Shift out the fraction (floor), then fit the result into DATA_SIZE bits.
   function automatic fx_res_t fx_narrow(input logic signed [ACC_W-1:0] acc);
      fx_res_t r;
`ifdef ZZ_DELTA_SATURATE_EN
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> FRAC_BITS;
      if (sh > SAT_MAX) begin
         r.val = SAT_MAX[DATA_SIZE-1:0];
         r.ovf = 1'b1;
      end else if (sh < SAT_MIN) begin
         r.val = SAT_MIN[DATA_SIZE-1:0];
         r.ovf = 1'b1;
      end else begin
         r.val = sh[DATA_SIZE-1:0];
         r.ovf = 1'b0;
      end
`else
      r.val = DATA_SIZE'(acc >>> FRAC_BITS);
      r.ovf = 1'b0;
`endif
      return r;
   endfunction

   function automatic fx_res_t fx_mult(input logic signed [DATA_SIZE-1:0] a,
                                       input logic signed [DATA_SIZE-1:0] b);
      logic signed [ACC_W-1:0] ae;
      logic signed [ACC_W-1:0] be;
      ae = ACC_W'(a);
      be = ACC_W'(b);
      return fx_narrow(ae * be);
   endfunction

endpackage

// File: rtl/zz_dot_unit.sv
// Combinational SIZE-lane dot product of g with one cost row, narrowed to DATA_SIZE.
// Narrowing behaviour follows ZZ_DELTA_SATURATE_EN through zz_pkg::fx_narrow.
module zz_dot_unit
   import zz_pkg::*;
(
   input  logic [DATA_SIZE*SIZE-1:0]  g_i,
   input  logic [DATA_SIZE*SIZE-1:0]  row_i,
   output logic signed [DATA_SIZE-1:0] y_o,
   output logic                        ovf_o
);

   logic signed [ACC_W-1:0] acc;
   fx_res_t                 res;

   // Full-precision accumulation; only the final narrow can lose information.
   always_comb begin
      acc = '0;
      for (int k = 0; k < SIZE; k++) begin
         acc = acc + ACC_W'($signed(g_i[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE]))
                   * ACC_W'($signed(row_i[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE]));
      end
      res = fx_narrow(acc);
   end

   assign y_o   = res.val;
   assign ovf_o = res.ovf;

endmodule

// File: rtl/zz_delta_stream_unit.sv
// Backprop delta engine: latches g = act (.) dense, then streams y_r = C[r].g per row.
// Saturating arithmetic and the overflow flag are enabled by ZZ_DELTA_SATURATE_EN.
module zz_delta_stream_unit
   import zz_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        start_layer_i,
   input  logic [DATA_SIZE*SIZE-1:0]   diff_act_i,
   input  logic [DATA_SIZE*SIZE-1:0]   diff_dense_i,
   input  logic                        vec_valid_i,
   output logic                        vec_ready_o,
   input  logic [DATA_SIZE*SIZE-1:0]   diff_cost_row_i,
   input  logic                        row_valid_i,
   output logic                        row_ready_o,
   output logic signed [DATA_SIZE-1:0] diff_z_out_o,
   output logic [IDX_W-1:0]            out_row_idx_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic                        layer_done_o,
   output logic [LAYER_W-1:0]          layer_idx_o,
   output logic                        busy_o,
   output logic                        overflow_o
);

   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(SIZE-1);

   zz_state_t                   state_q, state_d;
   logic [DATA_SIZE*SIZE-1:0]   g_q, g_d;
   logic [IDX_W-1:0]            row_cnt_q, row_cnt_d;
   logic                        out_valid_q, out_valid_d;
   logic signed [DATA_SIZE-1:0] z_q, z_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [LAYER_W-1:0]          layer_idx_q, layer_idx_d;
   logic                        ovf_q, ovf_d;

   logic [DATA_SIZE*SIZE-1:0]   g_load;
   logic                        g_load_ovf;
   fx_res_t                     mres;
   logic signed [DATA_SIZE-1:0] y_s;
   logic                        y_ovf_s;
   logic                        row_ready_s;
   logic                        row_fire_s;
   logic                        consume_s;

   zz_dot_unit u_dot (
      .g_i   (g_q),
      .row_i (diff_cost_row_i),
      .y_o   (y_s),
      .ovf_o (y_ovf_s)
   );

   // Element-wise g candidate from the presented vector pair.
   always_comb begin
      g_load     = '0;
      g_load_ovf = 1'b0;
      mres       = '0;
      for (int k = 0; k < SIZE; k++) begin
         mres = fx_mult(diff_act_i[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE],
                        diff_dense_i[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE]);
         g_load[DATA_SIZE*(SIZE-k)-1 -: DATA_SIZE] = mres.val;
         g_load_ovf = g_load_ovf | mres.ovf;
      end
   end

   assign consume_s   = out_valid_q & out_ready_i;
   assign row_ready_s = (state_q == ST_STREAM) & (~out_valid_q | out_ready_i);
   assign row_fire_s  = row_ready_s & row_valid_i;

   // Next-state logic for the layer sequencer and the output register.
   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      row_cnt_d   = row_cnt_q;
      z_d         = z_q;
      idx_d       = idx_q;
      layer_idx_d = layer_idx_q;
      ovf_d       = ovf_q;
      if (consume_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (start_layer_i) begin
               state_d = ST_LOAD;
               ovf_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (vec_valid_i) begin
               g_d       = g_load;
               row_cnt_d = '0;
               ovf_d     = ovf_q | g_load_ovf;
               state_d   = ST_STREAM;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_STREAM: begin
            if (row_fire_s) begin
               z_d         = y_s;
               idx_d       = row_cnt_q;
               out_valid_d = 1'b1;
               row_cnt_d   = row_cnt_q + IDX_W'(1);
               ovf_d       = ovf_q | y_ovf_s;
               if (row_cnt_q == LAST_ROW) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_STREAM;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if (consume_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            layer_idx_d = layer_idx_q + LAYER_W'(1);
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         g_q         <= '0;
         row_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         z_q         <= '0;
         idx_q       <= '0;
         layer_idx_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         row_cnt_q   <= row_cnt_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         idx_q       <= idx_d;
         layer_idx_q <= layer_idx_d;
         ovf_q       <= ovf_d;
      end
   end

   assign vec_ready_o   = (state_q == ST_LOAD);
   assign row_ready_o   = row_ready_s;
   assign busy_o        = (state_q != ST_IDLE);
   assign layer_done_o  = (state_q == ST_DONE);
   assign out_valid_o   = out_valid_q;
   assign diff_z_out_o  = z_q;
   assign out_row_idx_o = idx_q;
   assign layer_idx_o   = layer_idx_q;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_zz_delta_stream_unit.sv
// Scoreboard bench for zz_delta_stream_unit; expectations follow ZZ_DELTA_SATURATE_EN.
module tb_zz_delta_stream_unit;

   logic               clk = 1'b0;
   logic               reset;
   logic               start_layer;
   logic [47:0]        diff_act, diff_dense, diff_cost_row;
   logic               vec_valid, vec_ready, row_valid, row_ready;
   logic signed [15:0] diff_z_out;
   logic [1:0]         out_row_idx;
   logic               out_valid, out_ready, layer_done, busy, overflow;
   logic [3:0]         layer_idx;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_consume_cyc = -100;
   logic        prev_done = 1'b0;
   logic [17:0] sb_q[$];
   logic [17:0] mon_e;

   localparam logic [47:0] ACT1  = {16'd256, 16'd512, 16'd256};
   localparam logic [47:0] DEN1  = {16'd256, 16'd256, 16'hFF00};
   localparam logic [47:0] R0    = {16'd256, 16'd256, 16'd256};
   localparam logic [47:0] R1    = {16'd256, 16'd0,   16'd0};
   localparam logic [47:0] R2    = {16'd0,   16'd0,   16'd256};
   localparam logic [47:0] ACTM  = {16'h7FFF, 16'h7FFF, 16'h7FFF};
   localparam logic [47:0] DENU  = {16'd256, 16'd256, 16'd256};
   localparam logic [47:0] RZERO = 48'd0;
`ifdef ZZ_DELTA_SATURATE_EN
   localparam logic [15:0] Y_BIG   = 16'h7FFF;
   localparam logic [15:0] OVF_BIG = 16'd1;
`else
   localparam logic [15:0] Y_BIG   = 16'hFD00;
   localparam logic [15:0] OVF_BIG = 16'd0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   zz_delta_stream_unit dut (
      .clk_i(clk), .reset_i(reset), .start_layer_i(start_layer),
      .diff_act_i(diff_act), .diff_dense_i(diff_dense),
      .vec_valid_i(vec_valid), .vec_ready_o(vec_ready),
      .diff_cost_row_i(diff_cost_row), .row_valid_i(row_valid), .row_ready_o(row_ready),
      .diff_z_out_o(diff_z_out), .out_row_idx_o(out_row_idx),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .layer_done_o(layer_done), .layer_idx_o(layer_idx),
      .busy_o(busy), .overflow_o(overflow)
   );

   task automatic check(input string name, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks pulse widths.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         last_consume_cyc = cyc;
         if (sb_q.size() == 0) begin
            check("sb_unexpected_output", sb_q.size(), 1);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_y", diff_z_out, $signed(mon_e[15:0]));
            check("sb_idx", out_row_idx, mon_e[17:16]);
         end
      end
      if (!reset && layer_done) check("done_pulse_width", prev_done, 0);
      prev_done = layer_done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_layer = 1'b1;
      tick();
      start_layer = 1'b0;
   endtask

   task automatic send_vec(input logic [47:0] act, input logic [47:0] dense);
      bit ok = 1'b0;
      diff_act = act; diff_dense = dense; vec_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (vec_ready) begin ok = 1'b1; break; end
      end
      tick();
      vec_valid = 1'b0;
      check("vec_accept", ok, 1);
   endtask

   task automatic send_row(input logic [47:0] row, input logic [15:0] y, input logic [1:0] idx);
      bit ok = 1'b0;
      diff_cost_row = row; row_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (row_ready) begin ok = 1'b1; break; end
      end
      if (ok) sb_q.push_back({idx, y});
      tick();
      row_valid = 1'b0;
      check("row_accept", ok, 1);
   endtask

   task automatic wait_done(input int exp_idx);
      bit ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (layer_done) begin ok = 1'b1; break; end
      end
      check("done_seen", ok, 1);
      if (ok) check("done_latency", cyc - last_consume_cyc, 1);
      @(negedge clk);
      check("done_low", layer_done, 0);
      check("layer_idx", layer_idx, exp_idx);
      check("idle_after_done", busy, 0);
      check("sb_empty", sb_q.size(), 0);
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_vec_ready"}, vec_ready, 0);
      check({tag, "_row_ready"}, row_ready, 0);
      check({tag, "_layer_done"}, layer_done, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_layer_idx"}, layer_idx, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_diff_z_out"}, diff_z_out, 0);
      check({tag, "_out_row_idx"}, out_row_idx, 0);
   endtask

   task automatic std_layer(input int exp_idx);
      pulse_start();
      send_vec(ACT1, DEN1);
      send_row(R0, 16'd512, 2'd0);
      send_row(R1, 16'd256, 2'd1);
      send_row(R2, 16'hFF00, 2'd2);
      wait_done(exp_idx);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start_layer = 1'b0; vec_valid = 1'b0; row_valid = 1'b0;
      out_ready = 1'b1; diff_act = '0; diff_dense = '0; diff_cost_row = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      tick();
      reset = 1'b0;
      tick();

      // T1 basic layer
      std_layer(1);

      // T2 back-pressure after row 0
      pulse_start();
      send_vec(ACT1, DEN1);
      out_ready = 1'b0;
      send_row(R0, 16'd512, 2'd0);
      diff_cost_row = R1; row_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_row_ready", row_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_hold_z", diff_z_out, 512);
         check("bp_hold_idx", out_row_idx, 0);
      end
      tick();
      out_ready = 1'b1;
      send_row(R1, 16'd256, 2'd1);
      send_row(R2, 16'hFF00, 2'd2);
      wait_done(2);

      // T3 saturation / wrap
      pulse_start();
      send_vec(ACTM, DENU);
      send_row(ACTM, Y_BIG, 2'd0);
      send_row(RZERO, 16'd0, 2'd1);
      send_row(R1, 16'h7FFF, 2'd2);
      wait_done(3);
      check("t3_overflow_sticky", overflow, OVF_BIG);

      // T4 ignored events: row_valid in LOAD, start_layer in STREAM
      pulse_start();
      diff_cost_row = R0; row_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_load_row_ready", row_ready, 0);
         check("t4_load_out_valid", out_valid, 0);
         check("t4_load_vec_ready", vec_ready, 1);
         check("t4_overflow_cleared", overflow, 0);
      end
      tick();
      row_valid = 1'b0;
      send_vec(ACT1, DEN1);
      pulse_start();
      @(negedge clk);
      check("t4_stream_busy", busy, 1);
      check("t4_stream_vec_ready", vec_ready, 0);
      check("t4_stream_out_valid", out_valid, 0);
      tick();
      send_row(R0, 16'd512, 2'd0);
      send_row(R1, 16'd256, 2'd1);
      send_row(R2, 16'hFF00, 2'd2);
      wait_done(4);

      // T5 reset mid-STREAM after row 1
      pulse_start();
      send_vec(ACT1, DEN1);
      send_row(R0, 16'd512, 2'd0);
      send_row(R1, 16'd256, 2'd1);
      tick();
      check("t5_sb_drained", sb_q.size(), 0);
      reset = 1'b1;
      tick();
      @(negedge clk);
      check_all_zero("t5");
      tick();
      reset = 1'b0;
      sb_q.delete();
      tick();

      // T6 sixteen back-to-back layers, layer_idx wraps to 0
      for (int k = 0; k < 16; k++) begin
         std_layer((k + 1) % 16);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
